// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atm_pkg
// Brief    : Shared state encoding and constants for the ATM controller.
// Revision : 1.0 - initial release
// ============================================================================
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_RECIBIENDO_PIN = 3'd1,
        ST_VERIFICAR      = 3'd2,
        ST_TRANSACCION    = 3'd3,
        ST_BLOQUEO        = 3'd4
    } state_t;

    localparam int   PIN_DIGITS    = 4;
    localparam int   MAX_INTENTOS  = 3;
    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/atm_pin_capture.sv
`default_nettype none
// ============================================================================
// Module   : atm_pin_capture
// Brief    : Keypad strobe edge detect, PIN shift register and digit counter.
// Revision : 1.0 - initial release
// ============================================================================
module atm_pin_capture
    import atm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic        i_clear,
    input  logic        i_digito_stb,
    input  logic [3:0]  i_digito,
    output logic [15:0] o_pin,
    output logic        o_last
);

    localparam int                 CNT_W  = $clog2(PIN_DIGITS);
    localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(PIN_DIGITS - 1);

    logic             r_stb_prev;
    logic [15:0]      r_pin;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;

    // The previous strobe level is tracked in every state so a strobe held
    // across entry into PIN capture is not mistaken for a fresh press.
    assign w_accept = i_enable & i_digito_stb & ~r_stb_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stb_prev <= 1'b0;
            r_pin      <= 16'h0000;
            r_count    <= '0;
        end else begin
            r_stb_prev <= i_digito_stb;
            if (i_clear) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_pin   <= {r_pin[11:0], i_digito};
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_pin  = r_pin;
    assign o_last = w_accept && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/atm_controller.sv
`default_nettype none
// ============================================================================
// Module   : atm_controller
// Brief    : ATM session FSM: PIN check with lockout, deposit and withdrawal.
//            Define PIN_DEBUG_EN to expose the live PIN shift register on pin.
// Revision : 1.0 - initial release
// ============================================================================
module atm_controller
    import atm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tarjeta_recibida,
    input  logic        digito_stb,
    input  logic [3:0]  digito,
    input  logic [15:0] pin_correcto,
    input  logic        tipo_trans,
    input  logic [31:0] monto,
    input  logic [63:0] balance_inicial,
    output logic        pin_incorrecto,
    output logic        advertencia,
    output logic        bloqueo,
    output logic        balance_stb,
    output logic        entregar_dinero,
    output logic        fondos_insuficientes,
    output logic [63:0] balance_actualizado,
    output logic [15:0] pin
);

    state_t      r_state;
    logic [1:0]  r_intentos;
    logic [63:0] r_balance;
    logic        r_pin_incorrecto;
    logic        r_advertencia;
    logic        r_bloqueo;
    logic        r_balance_stb;
    logic        r_entregar;
    logic        r_fondos;

    logic        w_enable;
    logic        w_clear;
    logic        w_last;
    logic [15:0] w_pin;
    logic [1:0]  w_intentos_next;
    logic [63:0] w_monto_ext;

    assign w_enable        = (r_state == ST_RECIBIENDO_PIN) && tarjeta_recibida;
    assign w_clear         = ((r_state == ST_IDLE) && tarjeta_recibida) ||
                             (((r_state == ST_RECIBIENDO_PIN) ||
                               (r_state == ST_VERIFICAR)) && !tarjeta_recibida);
    assign w_intentos_next = r_intentos + 2'd1;
    assign w_monto_ext     = {32'b0, monto};

    atm_pin_capture u_pin_capture (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (w_enable),
        .i_clear      (w_clear),
        .i_digito_stb (digito_stb),
        .i_digito     (digito),
        .o_pin        (w_pin),
        .o_last       (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_intentos       <= 2'd0;
            r_balance        <= 64'd0;
            r_pin_incorrecto <= 1'b0;
            r_advertencia    <= 1'b0;
            r_bloqueo        <= 1'b0;
            r_balance_stb    <= 1'b0;
            r_entregar       <= 1'b0;
            r_fondos         <= 1'b0;
        end else begin
            r_pin_incorrecto <= 1'b0;
            r_balance_stb    <= 1'b0;
            r_entregar       <= 1'b0;
            r_fondos         <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tarjeta_recibida) begin
                        r_balance <= balance_inicial;
                        r_state   <= ST_RECIBIENDO_PIN;
                    end
                end
                ST_RECIBIENDO_PIN: begin
                    if (!tarjeta_recibida) begin
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        r_state <= ST_VERIFICAR;
                    end
                end
                ST_VERIFICAR: begin
                    if (!tarjeta_recibida) begin
                        r_state <= ST_IDLE;
                    end else if (w_pin == pin_correcto) begin
                        r_intentos    <= 2'd0;
                        r_advertencia <= 1'b0;
                        r_state       <= ST_TRANSACCION;
                    end else begin
                        r_intentos <= w_intentos_next;
                        if (w_intentos_next == 2'(MAX_INTENTOS)) begin
                            r_bloqueo <= 1'b1;
                            r_state   <= ST_BLOQUEO;
                        end else begin
                            r_pin_incorrecto <= 1'b1;
                            if (w_intentos_next == 2'(MAX_INTENTOS - 1)) begin
                                r_advertencia <= 1'b1;
                            end
                            r_state <= ST_RECIBIENDO_PIN;
                        end
                    end
                end
                ST_TRANSACCION: begin
                    if (tipo_trans == TIPO_DEPOSITO) begin
                        r_balance     <= r_balance + w_monto_ext;
                        r_balance_stb <= 1'b1;
                    end else if (w_monto_ext <= r_balance) begin
                        r_balance     <= r_balance - w_monto_ext;
                        r_balance_stb <= 1'b1;
                        r_entregar    <= 1'b1;
                    end else begin
                        r_fondos <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                ST_BLOQUEO: begin
                    r_bloqueo <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pin_incorrecto       = r_pin_incorrecto;
    assign advertencia          = r_advertencia;
    assign bloqueo              = r_bloqueo;
    assign balance_stb          = r_balance_stb;
    assign entregar_dinero      = r_entregar;
    assign fondos_insuficientes = r_fondos;
    assign balance_actualizado  = r_balance;

`ifdef PIN_DEBUG_EN
    assign pin = w_pin;
`else
    assign pin = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_atm_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm_controller
// Brief    : Scoreboard bench for atm_controller using directed sessions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm_controller;

    typedef struct packed {
        logic        bal_stb;
        logic        entregar;
        logic        fondos;
        logic        pin_inc;
        logic        advert;
        logic [63:0] bal;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        tarjeta_recibida;
    logic        digito_stb;
    logic [3:0]  digito;
    logic [15:0] pin_correcto;
    logic        tipo_trans;
    logic [31:0] monto;
    logic [63:0] balance_inicial;
    logic        pin_incorrecto;
    logic        advertencia;
    logic        bloqueo;
    logic        balance_stb;
    logic        entregar_dinero;
    logic        fondos_insuficientes;
    logic [63:0] balance_actualizado;
    logic [15:0] pin;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    atm_controller dut (
        .clk                  (clk),
        .reset                (reset),
        .tarjeta_recibida     (tarjeta_recibida),
        .digito_stb           (digito_stb),
        .digito               (digito),
        .pin_correcto         (pin_correcto),
        .tipo_trans           (tipo_trans),
        .monto                (monto),
        .balance_inicial      (balance_inicial),
        .pin_incorrecto       (pin_incorrecto),
        .advertencia          (advertencia),
        .bloqueo              (bloqueo),
        .balance_stb          (balance_stb),
        .entregar_dinero      (entregar_dinero),
        .fondos_insuficientes (fondos_insuficientes),
        .balance_actualizado  (balance_actualizado),
        .pin                  (pin)
    );

    always #5 clk = ~clk;

    // Monitor: every pulse the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        exp_t got, e;
        if (!reset && (balance_stb | entregar_dinero | fondos_insuficientes | pin_incorrecto)) begin
            got = '{balance_stb, entregar_dinero, fondos_insuficientes,
                    pin_incorrecto, advertencia, balance_actualizado};
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_event: got stb=%b ent=%b fondos=%b pin_inc=%b adv=%b bal=%0d, required no event",
                         got.bal_stb, got.entregar, got.fondos, got.pin_inc, got.advert, got.bal);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_errors++;
                    $display("FAIL event: got stb=%b ent=%b fondos=%b pin_inc=%b adv=%b bal=%0d, required stb=%b ent=%b fondos=%b pin_inc=%b adv=%b bal=%0d",
                             got.bal_stb, got.entregar, got.fondos, got.pin_inc, got.advert, got.bal,
                             e.bal_stb, e.entregar, e.fondos, e.pin_inc, e.advert, e.bal);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send_digit(input logic [3:0] d);
        @(negedge clk);
        digito     = d;
        digito_stb = 1'b1;
        @(negedge clk);
        digito_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_pin(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) send_digit(p[4*i +: 4]);
    endtask

    task automatic wait_empty(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic card_cycle();
        tarjeta_recibida = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic session(input string name, input logic [63:0] bal0, input logic tipo,
                           input logic [31:0] m, input exp_t e);
        balance_inicial = bal0;
        tipo_trans      = tipo;
        monto           = m;
        sb.push_back(e);
        tarjeta_recibida = 1'b1;
        repeat (2) @(negedge clk);
        send_pin(16'h3257);
        wait_empty(name);
        card_cycle();
    endtask

    initial begin
        reset            = 1'b1;
        tarjeta_recibida = 1'b0;
        digito_stb       = 1'b0;
        digito           = 4'h0;
        pin_correcto     = 16'h3257;
        tipo_trans       = 1'b0;
        monto            = 32'd0;
        balance_inicial  = 64'd1000;
        repeat (3) @(negedge clk);
        check("reset_outputs", {58'd0, pin_incorrecto, advertencia, bloqueo, balance_stb,
                                entregar_dinero, fondos_insuficientes}, 64'd0);
        check("reset_balance", balance_actualizado, 64'd0);
        check("reset_pin", {48'd0, pin}, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        session("deposit", 64'd1000, 1'b0, 32'd100, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1100});
        session("withdraw", 64'd1000, 1'b1, 32'd50, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd950});
        session("no_funds", 64'd1000, 1'b1, 32'd2000, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd1000});
        session("withdraw_all", 64'd50, 1'b1, 32'd50, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0});
        session("deposit_wrap", 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 32'h20,
                '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h10});

        // Held strobe: a 3-cycle strobe counts once, so 3 then 2,5,7 is correct.
        balance_inicial = 64'd1000;
        tipo_trans = 1'b0;
        monto = 32'd7;
        sb.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1007});
        tarjeta_recibida = 1'b1;
        repeat (2) @(negedge clk);
        digito = 4'h3;
        digito_stb = 1'b1;
        repeat (3) @(negedge clk);
        digito_stb = 1'b0;
        @(negedge clk);
        send_digit(4'h2);
        send_digit(4'h5);
        send_digit(4'h7);
        wait_empty("held_strobe");
        card_cycle();

        // Card removed after two digits, then a clean entry.
        monto = 32'd5;
        tarjeta_recibida = 1'b1;
        repeat (2) @(negedge clk);
        send_digit(4'h1);
        send_digit(4'h1);
        card_cycle();
        session("card_removal", 64'd1000, 1'b0, 32'd5, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1005});

        // Lockout after three wrong entries.
        balance_inicial = 64'd1000;
        tarjeta_recibida = 1'b1;
        repeat (2) @(negedge clk);
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd1000});
        send_pin(16'h5555);
        wait_empty("wrong_1");
        check("advert_after_1", {63'd0, advertencia}, 64'd0);
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd1000});
        send_pin(16'h5555);
        wait_empty("wrong_2");
        check("advert_after_2", {63'd0, advertencia}, 64'd1);
        check("no_lock_after_2", {63'd0, bloqueo}, 64'd0);
        send_pin(16'h5555);
        repeat (5) @(negedge clk);
        check("lock_after_3", {63'd0, bloqueo}, 64'd1);
        send_pin(16'h3257);
        repeat (5) @(negedge clk);
        check("lock_ignores_pin", {63'd0, bloqueo}, 64'd1);
        check("lock_balance", balance_actualizado, 64'd1000);
        reset = 1'b1;
        @(negedge clk);
        check("reset_unlock", {62'd0, bloqueo, advertencia}, 64'd0);
        check("reset_balance_2", balance_actualizado, 64'd0);
        reset = 1'b0;
        tarjeta_recibida = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/atm_controller.md
ATM_CONTROLLER -- requirements
Module: atm_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port tarjeta_recibida, input, 1 bit: card present (level).
REQ-004 SHALL have port digito_stb, input, 1 bit: keypad digit strobe.
REQ-005 SHALL have port digito, input, 4 bits: keypad digit 0x0-0x9, valid with digito_stb.
REQ-006 SHALL have port pin_correcto, input, 16 bits: stored PIN, 4 BCD nibbles, MSB nibble first.
REQ-007 SHALL have port tipo_trans, input, 1 bit: 0 = deposit, 1 = withdrawal.
REQ-008 SHALL have port monto, input, 32 bits: transaction amount, unsigned.
REQ-009 SHALL have port balance_inicial, input, 64 bits: account balance, unsigned.
REQ-010 SHALL have outputs pin_incorrecto, advertencia, bloqueo, balance_stb, entregar_dinero and fondos_insuficientes, each 1 bit.
REQ-011 SHALL have output balance_actualizado, 64 bits, and output pin, 16 bits: captured PIN.

Function
REQ-012 SHALL implement states IDLE, RECIBIENDO_PIN, VERIFICAR, TRANSACCION and BLOQUEO.
REQ-013 IDLE SHALL go to RECIBIENDO_PIN when tarjeta_recibida=1, loading the balance register from balance_inicial and clearing the digit count.
REQ-014 A digit SHALL be accepted only on a rising edge of digito_stb (registered previous value is 0, current value is 1) while in RECIBIENDO_PIN; strobes in other states are ignored.
REQ-015 Each accepted digit SHALL shift in as pin <= {pin[11:0], digito} and increment a 2-bit digit count.
REQ-016 The 4th accepted digit SHALL move the FSM to VERIFICAR on the next edge.
REQ-017 In VERIFICAR, pin==pin_correcto SHALL clear the attempt counter and go to TRANSACCION.
REQ-018 In VERIFICAR, a mismatch SHALL increment the attempt counter and act on the new count:
- 1: pulse pin_incorrecto for 1 cycle, then return to RECIBIENDO_PIN.
- 2: pulse pin_incorrecto and set advertencia high, held until a correct PIN or reset; then return to RECIBIENDO_PIN.
- 3: go to BLOQUEO.
REQ-019 BLOQUEO SHALL hold bloqueo=1 and ignore all inputs until reset.
REQ-020 TRANSACCION SHALL last exactly 1 cycle, then go to IDLE.
REQ-021 A deposit in TRANSACCION SHALL compute balance = balance + {32'b0, monto}, modulo 2^64, and pulse balance_stb for that cycle.
REQ-022 A withdrawal with monto <= balance SHALL compute balance - monto and pulse balance_stb and entregar_dinero for 1 cycle.
REQ-023 A withdrawal with monto > balance SHALL pulse fondos_insuficientes for 1 cycle and leave the balance unchanged.
REQ-024 balance_actualizado SHALL continuously reflect the balance register; on a success it updates on the same edge that raises balance_stb.
REQ-025 tarjeta_recibida=0 in RECIBIENDO_PIN or VERIFICAR SHALL return the FSM to IDLE and clear the digit count; the attempt counter is retained.
REQ-026 An acceptance of a digit and a VERIFICAR decision SHALL never fall on the same cycle, because digits are ignored outside RECIBIENDO_PIN.

Reset
REQ-027 While reset=1 the block SHALL hold:
- state=IDLE, digit count=0, attempts=0.
- pin=16'h0000, balance register=0.
- all 1-bit outputs at 0.
REQ-028 Reset asserted mid-operation SHALL abort immediately with no pulse output; it is the only exit from BLOQUEO.

Configuration
REQ-029 With PIN_DEBUG_EN defined, output pin SHALL show the live shift register.
REQ-030 Without PIN_DEBUG_EN, pin SHALL be tied to 16'h0000 and the shift register SHALL be internal only.

Structure
REQ-031 Shared package atm_pkg SHALL hold the state encoding, PIN_DIGITS=4, MAX_INTENTOS=3 and the TIPO_DEPOSITO/TIPO_RETIRO constants.
REQ-032 Sub-module atm_pin_capture SHALL hold the strobe edge detect, shift register and digit counter; the FSM and arithmetic stay in atm_controller.

Verification
REQ-033 Correct PIN:
- Stimulus: balance_inicial=1000, pin_correcto=16'h3257; card in; digits 3,2,5,7; tipo_trans=0, monto=100.
- Response: balance_stb pulses, balance_actualizado=1100, no pin_incorrecto.
REQ-034 Withdrawal:
- Stimulus: re-entry with tipo_trans=1, monto=50.
- Response: balance_stb and entregar_dinero each pulse once, balance_actualizado=950 (balance reloaded from 1000).
REQ-035 Insufficient funds:
- Stimulus: monto=2000, withdrawal.
- Response: fondos_insuficientes pulses, no entregar_dinero, balance_actualizado=1000.
REQ-036 Lockout:
- Stimulus: three wrong entries 5,5,5,5.
- Response: pin_incorrecto pulses twice, advertencia=1 after the 2nd, bloqueo=1 after the 3rd.
- Follow-up: a 4th entry of 3,2,5,7 is ignored; reset clears bloqueo.
REQ-037 Held strobe:
- Stimulus: digito_stb held high for 3 cycles with digito=3.
- Response: exactly one digit accepted.
REQ-038 Card removal:
- Stimulus: card removed after 2 digits, then reinserted and 3,2,5,7 entered.
- Response: PIN accepted, no pin_incorrecto.
